frv_rng_arbiter: RTL and testbench
==================================

// Module: frv_rng_arbiter
//
// PURPOSE
//  Shares one external RNG request/response port between NREQ requesters,
//  for example the core RNG interface and a debug/crypto engine.
//  Grants the request channel one requester at a time.
//  Records the winner's ID in a tag FIFO, and routes each RNG response back
//  to the head-of-FIFO requester, in order.
//  Sits between the requester-side RNG interfaces and the top-level RNG port.
//
// PARAMETERS
//  NREQ   2  number of requesters (2..4)
//  OUTST  2  max RNG requests accepted but not yet answered (tag FIFO depth, power of 2)
//
// PORTS
//  g_clk           in   1         clock; all state on posedge
//  g_reset         in   1         asynchronous, active-high reset
//  req_valid       in   NREQ      per-requester request valid
//  req_op          in   3*NREQ    per-requester op {test,samp,seed}, slice i = [3i+2:3i]
//  req_data        in   32*NREQ   per-requester seed/init data
//  req_ready       out  NREQ      request accepted (one-hot or zero)
//  rsp_valid       out  NREQ      response valid to requester i (one-hot or zero)
//  rsp_status      out  3         RNG status, broadcast to all requesters
//  rsp_data        out  32        RNG sample data, broadcast to all requesters
//  rsp_ready       in   NREQ      requester i accepts its response
//  rng_req_valid   out  1         request to RNG
//  rng_req_op      out  3         op of the granted requester
//  rng_req_data    out  32        data of the granted requester
//  rng_req_ready   in   1         RNG accepts request
//  rng_rsp_valid   in   1         RNG response valid
//  rng_rsp_status  in   3         RNG status
//  rng_rsp_data    in   32        RNG response data
//  rng_rsp_ready   out  1         arbiter accepts response
//  err_spurious    out  1         sticky: response arrived with no outstanding tag
//
// BEHAVIOUR
//  Reset state
//  - Reset clears: tag FIFO empty, grant lock clear, RR pointer = 0, err_spurious = 0.
//  - During reset all outputs are 0 except rng_rsp_ready, which is 1 (FIFO empty).
//
//  Arbitration (combinational grant; 0-cycle request pass-through)
//  - Eligible set = req_valid. Winner is the first set bit at or after the RR pointer.
//  - rng_req_valid = winner exists && !fifo_full.
//  - rng_req_op and rng_req_data are muxed from the winner; 0 when there is no winner.
//  - Lock: if rng_req_valid=1 and rng_req_ready=0, register the winner.
//    While locked, the grant is held on that requester regardless of other requests.
//  - Requesters must hold valid, op and data stable until req_ready.
//  - Accept = rng_req_valid && rng_req_ready. On accept:
//    - req_ready[winner] = 1;
//    - push the winner ID into the tag FIFO;
//    - RR pointer = winner + 1 (mod NREQ);
//    - clear the lock.
//  - When fifo_full, rng_req_valid = 0, even with a lock held.
//    Push is gated on the registered full flag only. A same-cycle pop does not allow a push.
//
//  Response routing
//  - head = tag FIFO head ID.
//  - If the FIFO is non-empty:
//    - rsp_valid[head] = rng_rsp_valid;
//    - rng_rsp_ready = rsp_ready[head];
//    - pop on rng_rsp_valid && rng_rsp_ready.
//  - If the FIFO is empty:
//    - rng_rsp_ready = 1, so spurious responses are drained and dropped;
//    - a spurious response sets err_spurious, which stays set until reset;
//    - no rsp_valid is raised.
//  - A push and a pop in the same cycle are legal: count is unchanged, pointers both advance.
//  - Responses return in request order. The RNG is required to respond in order.
//  - Reset mid-transaction drops all tags. Responses still in flight after reset count as spurious.
//
// CONFIGURATION
//  FRV_RNG_ARB_FIXED_PRIO_EN
//  - defined: fixed priority; the lowest index wins; the RR pointer is removed.
//  - undefined: round-robin as above.
//  - Lock, FIFO and routing behaviour are identical in both builds.
//
// STRUCTURE
//  - mypackage gains:
//    - RNG_OP_W = 3;
//    - RNG_OP_TEST/SAMP/SEED bit indices;
//    - localparams for ID width ($clog2(NREQ), min 1).
//  - Sub-module frv_rng_arb_tagfifo:
//    - synchronous FIFO, depth OUTST, ID-wide entries;
//    - ports: push, pop, din, dout, full, empty;
//    - uses the same asynchronous active-high reset.
//
// TESTING
//  1 Single request: req0 samp, rng_req_ready=1, then rsp data 0xDEADBEEF
//    -> req_ready[0] in the same cycle; rsp_valid=01 with rsp_data=0xDEADBEEF.
//  2 Contention (RR): req0 and req1 held valid for 4 accepts
//    -> grant order 0,1,0,1. With FIXED_PRIO_EN -> 0,0,0,0.
//  3 Lock: req1 granted, rng_req_ready=0 for 3 cycles, req0 raised in cycle 2
//    -> rng_req_op stays req1's op; req1 accepted first.
//  4 Full: OUTST=2, two accepts with no response
//    -> rng_req_valid=0. One response with rsp_ready -> rng_req_valid=1 the next cycle.
//  5 Ordering/backpressure: accept req0 then req1; rsp_ready[0]=0 for 2 cycles
//    -> rng_rsp_ready=0 meanwhile; 1st rsp goes to req0, 2nd to req1.
//  6 Spurious/reset: rng_rsp_valid with empty FIFO -> rng_rsp_ready=1, err_spurious=1.
//    Assert g_reset mid-cycle -> outputs clear immediately.

Source files
------------

// File: rtl/frv_rng_arbiter_pkg.sv
// Shared constants for the RNG port arbiter: op encoding and requester ID sizing.
package frv_rng_arbiter_pkg;

    localparam int unsigned RNG_OP_W    = 3;
    localparam int unsigned RNG_OP_SEED = 0;
    localparam int unsigned RNG_OP_SAMP = 1;
    localparam int unsigned RNG_OP_TEST = 2;

    localparam int unsigned RNG_DATA_W  = 32;
    localparam int unsigned RNG_STAT_W  = 3;

    // Requester ID width; a single-bit ID is kept even for one requester.
    function automatic int unsigned arb_id_w(input int unsigned nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/frv_rng_arb_tagfifo.sv
// In-order tag FIFO holding the requester ID of every RNG request still awaiting a response.
module frv_rng_arb_tagfifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_q];

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= (wr_q == PTR_W'(DEPTH-1)) ? '0 : wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= (rd_q == PTR_W'(DEPTH-1)) ? '0 : rd_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge g_clk) begin
        if (do_push) begin
            mem[wr_q] <= din;
        end
    end

endmodule

// File: rtl/frv_rng_arbiter.sv
// Shares one RNG request/response port among NREQ requesters and routes responses back in order.
// Build option FRV_RNG_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module frv_rng_arbiter
    import frv_rng_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned OUTST = 2
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [RNG_OP_W*NREQ-1:0]   req_op,
    input  logic [RNG_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [RNG_STAT_W-1:0]      rsp_status,
    output logic [RNG_DATA_W-1:0]      rsp_data,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic                       rng_req_valid,
    output logic [RNG_OP_W-1:0]        rng_req_op,
    output logic [RNG_DATA_W-1:0]      rng_req_data,
    input  logic                       rng_req_ready,
    input  logic                       rng_rsp_valid,
    input  logic [RNG_STAT_W-1:0]      rng_rsp_status,
    input  logic [RNG_DATA_W-1:0]      rng_rsp_data,
    output logic                       rng_rsp_ready,
    output logic                       err_spurious
);

    localparam int unsigned ID_W = arb_id_w(NREQ);

    logic            lock_q;
    logic [ID_W-1:0] lock_id_q;
    logic            win_vld_c;
    logic [ID_W-1:0] win_id_c;
    logic            gnt_vld_c;
    logic            accept_c;
    logic            pop_c;
    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] head_id;

`ifndef FRV_RNG_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_q;
    logic [ID_W:0]   idx_c;
`endif

    // Winner selection: a held lock overrides arbitration.
    always_comb begin
        win_vld_c = 1'b0;
        win_id_c  = '0;
`ifndef FRV_RNG_ARB_FIXED_PRIO_EN
        idx_c     = '0;
`endif
        if (lock_q) begin
            win_vld_c = 1'b1;
            win_id_c  = lock_id_q;
        end else begin
`ifdef FRV_RNG_ARB_FIXED_PRIO_EN
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!win_vld_c && req_valid[i]) begin
                    win_vld_c = 1'b1;
                    win_id_c  = ID_W'(i);
                end
            end
`else
            for (int k = 0; k < int'(NREQ); k++) begin
                idx_c = {1'b0, rr_q} + (ID_W+1)'(k);
                if (idx_c >= (ID_W+1)'(NREQ)) begin
                    idx_c = idx_c - (ID_W+1)'(NREQ);
                end
                if (!win_vld_c && req_valid[idx_c[ID_W-1:0]]) begin
                    win_vld_c = 1'b1;
                    win_id_c  = idx_c[ID_W-1:0];
                end
            end
`endif
        end
    end

    assign gnt_vld_c     = win_vld_c && !g_reset;
    assign rng_req_valid = gnt_vld_c && !fifo_full;
    assign accept_c      = rng_req_valid && rng_req_ready;
    assign req_ready     = accept_c ? (NREQ'(1) << win_id_c) : '0;

    always_comb begin
        rng_req_op   = '0;
        rng_req_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_vld_c && (win_id_c == ID_W'(i))) begin
                rng_req_op   = req_op[RNG_OP_W*i +: RNG_OP_W];
                rng_req_data = req_data[RNG_DATA_W*i +: RNG_DATA_W];
            end
        end
    end

    // Response routing to the oldest outstanding requester; drain when nothing is owed.
    assign rng_rsp_ready = fifo_empty ? 1'b1 : rsp_ready[head_id];
    assign rsp_valid     = (!fifo_empty && rng_rsp_valid) ? (NREQ'(1) << head_id) : '0;
    assign pop_c         = !fifo_empty && rng_rsp_valid && rng_rsp_ready;
    assign rsp_status    = g_reset ? '0 : rng_rsp_status;
    assign rsp_data      = g_reset ? '0 : rng_rsp_data;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (accept_c) begin
                lock_q <= 1'b0;
            end else if (rng_req_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= win_id_c;
            end
            if (fifo_empty && rng_rsp_valid) begin
                err_spurious <= 1'b1;
            end
        end
    end

`ifndef FRV_RNG_ARB_FIXED_PRIO_EN
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            rr_q <= '0;
        end else if (accept_c) begin
            rr_q <= (win_id_c == ID_W'(NREQ-1)) ? '0 : win_id_c + ID_W'(1);
        end
    end
`endif

    frv_rng_arb_tagfifo #(
        .DEPTH (OUTST),
        .W     (ID_W)
    ) u_tagfifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (accept_c),
        .pop     (pop_c),
        .din     (win_id_c),
        .dout    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_frv_rng_arbiter.sv
// Directed bench for frv_rng_arbiter with NREQ=2, OUTST=2; honours FRV_RNG_ARB_FIXED_PRIO_EN.
module tb_frv_rng_arbiter;

    localparam logic [2:0] OP_SEED = 3'b001;
    localparam logic [2:0] OP_SAMP = 3'b010;
    localparam logic [2:0] OP_TEST = 3'b100;

    logic        g_clk;
    logic        g_reset;
    logic [1:0]  req_valid;
    logic [5:0]  req_op;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_ready;
    logic        rng_req_valid;
    logic [2:0]  rng_req_op;
    logic [31:0] rng_req_data;
    logic        rng_req_ready;
    logic        rng_rsp_valid;
    logic [2:0]  rng_rsp_status;
    logic [31:0] rng_rsp_data;
    logic        rng_rsp_ready;
    logic        err_spurious;

    int tests;
    int fails;
    logic [1:0] exp_gnt [4];

    frv_rng_arbiter #(.NREQ(2), .OUTST(2)) dut (
        .g_clk          (g_clk),
        .g_reset        (g_reset),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_status     (rsp_status),
        .rsp_data       (rsp_data),
        .rsp_ready      (rsp_ready),
        .rng_req_valid  (rng_req_valid),
        .rng_req_op     (rng_req_op),
        .rng_req_data   (rng_req_data),
        .rng_req_ready  (rng_req_ready),
        .rng_rsp_valid  (rng_rsp_valid),
        .rng_rsp_status (rng_rsp_status),
        .rng_rsp_data   (rng_rsp_data),
        .rng_rsp_ready  (rng_rsp_ready),
        .err_spurious   (err_spurious)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        req_valid      = '0;
        rsp_ready      = '0;
        rng_req_ready  = 1'b0;
        rng_rsp_valid  = 1'b0;
        rng_rsp_status = '0;
        rng_rsp_data   = '0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        g_reset = 1'b1;
        next_cyc();
        g_reset = 1'b0;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        req_op   = {OP_SEED, OP_SAMP};
        req_data = {32'h2222_2222, 32'h1111_1111};
        idle_inputs();
        g_reset  = 1'b1;

        // Reset state, with requests already pending
        req_valid = 2'b11;
        rng_req_ready = 1'b1;
        next_cyc();
        settle();
        chk("rst_rng_req_valid", 64'(rng_req_valid), 64'd0);
        chk("rst_rng_req_op", 64'(rng_req_op), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rng_rsp_ready", 64'(rng_rsp_ready), 64'd1);
        chk("rst_err", 64'(err_spurious), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        next_cyc();
        idle_inputs();
        g_reset = 1'b0;

        // 1: single request and response
        req_valid     = 2'b01;
        rng_req_ready = 1'b1;
        settle();
        chk("t1_req_valid", 64'(rng_req_valid), 64'd1);
        chk("t1_req_op", 64'(rng_req_op), 64'(OP_SAMP));
        chk("t1_req_data", 64'(rng_req_data), 64'h1111_1111);
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        next_cyc();
        idle_inputs();
        rng_rsp_valid  = 1'b1;
        rng_rsp_status = 3'b001;
        rng_rsp_data   = 32'hDEAD_BEEF;
        rsp_ready      = 2'b01;
        settle();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_data", 64'(rsp_data), 64'hDEAD_BEEF);
        chk("t1_rsp_status", 64'(rsp_status), 64'h1);
        chk("t1_rng_rsp_ready", 64'(rng_rsp_ready), 64'd1);
        next_cyc();
        idle_inputs();
        settle();
        chk("t1_drained_err", 64'(err_spurious), 64'd0);

        // 2: contention, responses streamed back one cycle behind
        next_cyc();
        reset_pulse();
`ifdef FRV_RNG_ARB_FIXED_PRIO_EN
        exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            req_valid     = 2'b11;
            rng_req_ready = 1'b1;
            rng_rsp_valid = (i > 0);
            settle();
            chk($sformatf("t2_grant%0d", i), 64'(req_ready), 64'(exp_gnt[i]));
            if (i > 0) begin
                chk($sformatf("t2_route%0d", i), 64'(rsp_valid), 64'(exp_gnt[i-1]));
            end
            next_cyc();
        end
        req_valid     = '0;
        rng_req_ready = 1'b0;
        rng_rsp_valid = 1'b1;
        settle();
        chk("t2_route_last", 64'(rsp_valid), 64'(exp_gnt[3]));
        next_cyc();
        idle_inputs();

        // 3: lock holds grant on req1 while the RNG stalls
        reset_pulse();
        req_op    = {OP_SEED, OP_TEST};
        req_valid = 2'b10;
        settle();
        chk("t3_c1_valid", 64'(rng_req_valid), 64'd1);
        chk("t3_c1_op", 64'(rng_req_op), 64'(OP_SEED));
        chk("t3_c1_ready", 64'(req_ready), 64'd0);
        next_cyc();
        req_valid = 2'b11;
        settle();
        chk("t3_c2_op", 64'(rng_req_op), 64'(OP_SEED));
        chk("t3_c2_data", 64'(rng_req_data), 64'h2222_2222);
        next_cyc();
        settle();
        chk("t3_c3_op", 64'(rng_req_op), 64'(OP_SEED));
        next_cyc();
        rng_req_ready = 1'b1;
        settle();
        chk("t3_acc1", 64'(req_ready), 64'h2);
        next_cyc();
        req_valid = 2'b01;
        settle();
        chk("t3_acc2", 64'(req_ready), 64'h1);
        chk("t3_acc2_op", 64'(rng_req_op), 64'(OP_TEST));
        next_cyc();
        idle_inputs();
        rsp_ready     = 2'b11;
        rng_rsp_valid = 1'b1;
        settle();
        chk("t3_rsp1", 64'(rsp_valid), 64'h2);
        next_cyc();
        settle();
        chk("t3_rsp2", 64'(rsp_valid), 64'h1);
        next_cyc();
        idle_inputs();

        // 4: tag FIFO full blocks requests; a same-cycle pop does not free a slot
        req_op        = {OP_SEED, OP_SAMP};
        req_valid     = 2'b01;
        rng_req_ready = 1'b1;
        settle();
        chk("t4_acc1", 64'(req_ready), 64'h1);
        next_cyc();
        settle();
        chk("t4_acc2", 64'(req_ready), 64'h1);
        next_cyc();
        rng_rsp_valid = 1'b1;
        rsp_ready     = 2'b01;
        settle();
        chk("t4_full_valid", 64'(rng_req_valid), 64'd0);
        chk("t4_full_ready", 64'(req_ready), 64'd0);
        chk("t4_full_rsp", 64'(rsp_valid), 64'h1);
        next_cyc();
        rng_rsp_valid = 1'b0;
        settle();
        chk("t4_reopen_valid", 64'(rng_req_valid), 64'd1);
        chk("t4_reopen_ready", 64'(req_ready), 64'h1);
        next_cyc();
        req_valid     = '0;
        rng_req_ready = 1'b0;
        rng_rsp_valid = 1'b1;
        next_cyc();
        settle();
        chk("t4_drain", 64'(rsp_valid), 64'h1);
        next_cyc();
        idle_inputs();
        settle();
        chk("t4_empty_ready", 64'(rng_rsp_ready), 64'd1);
        next_cyc();

        // 5: in-order routing under backpressure
        req_valid     = 2'b01;
        rng_req_ready = 1'b1;
        settle();
        chk("t5_acc0", 64'(req_ready), 64'h1);
        next_cyc();
        req_valid = 2'b10;
        settle();
        chk("t5_acc1", 64'(req_ready), 64'h2);
        next_cyc();
        idle_inputs();
        rng_rsp_valid = 1'b1;
        rng_rsp_data  = 32'hAAAA_0000;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("t5_bp_ready%0d", i), 64'(rng_rsp_ready), 64'd0);
            chk($sformatf("t5_bp_valid%0d", i), 64'(rsp_valid), 64'h1);
            next_cyc();
        end
        rsp_ready = 2'b01;
        settle();
        chk("t5_rsp0_ready", 64'(rng_rsp_ready), 64'd1);
        chk("t5_rsp0_data", 64'(rsp_data), 64'hAAAA_0000);
        next_cyc();
        rng_rsp_data = 32'hBBBB_1111;
        rsp_ready    = 2'b10;
        settle();
        chk("t5_rsp1_valid", 64'(rsp_valid), 64'h2);
        chk("t5_rsp1_ready", 64'(rng_rsp_ready), 64'd1);
        next_cyc();
        idle_inputs();
        settle();
        chk("t5_err_clear", 64'(err_spurious), 64'd0);
        next_cyc();

        // 6: spurious response, then asynchronous reset with a tag outstanding
        rng_rsp_valid = 1'b1;
        settle();
        chk("t6_sp_ready", 64'(rng_rsp_ready), 64'd1);
        chk("t6_sp_valid", 64'(rsp_valid), 64'd0);
        next_cyc();
        rng_rsp_valid = 1'b0;
        settle();
        chk("t6_err_set", 64'(err_spurious), 64'd1);
        next_cyc();
        settle();
        chk("t6_err_sticky", 64'(err_spurious), 64'd1);
        next_cyc();
        req_valid     = 2'b01;
        rng_req_ready = 1'b1;
        next_cyc();
        rng_req_ready = 1'b0;
        settle();
        chk("t6_pre_valid", 64'(rng_req_valid), 64'd1);
        chk("t6_pre_rsp_ready", 64'(rng_rsp_ready), 64'd0);
        #1;
        g_reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(rng_req_valid), 64'd0);
        chk("t6_rst_err", 64'(err_spurious), 64'd0);
        chk("t6_rst_rsp_ready", 64'(rng_rsp_ready), 64'd1);
        next_cyc();
        idle_inputs();
        g_reset       = 1'b0;
        rng_rsp_valid = 1'b1;
        rsp_ready     = 2'b01;
        settle();
        chk("t6_late_valid", 64'(rsp_valid), 64'd0);
        next_cyc();
        rng_rsp_valid = 1'b0;
        settle();
        chk("t6_late_err", 64'(err_spurious), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
